drv_led_arb: RTL and testbench

Per-drive activity LED arbiter for the Status CPLD. It sits between the two SGPIO decoders and the 72 drive activity cathode pins, and merges four sources per drive: SGPIO activity, host-written locate blink, a test sweep, and per-channel SGPIO link-loss gating. The host configures it through the I2C/GPIO register port, as a new PORT_CS slot.

---
 rtl/status_define.sv | 37 +++
 rtl/sgpio_link_wdog.sv | 43 ++++
 rtl/drv_led_arb.sv | 193 +++++++++++++++++++
 tb/tb_drv_led_arb.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/status_define.sv
// Shared constants for the Status CPLD drive LED logic: register offsets,
// CTRL bit positions and reset value, drive/group geometry, sweep FSM states
// and the drive-to-SGPIO-source mapping helpers.
package status_define;

  localparam int unsigned NUM_DRV      = 72;
  localparam int unsigned GRP_W        = 12;
  localparam int unsigned CH_W         = 36;
  localparam int unsigned IDX_W        = 7;
  localparam int unsigned NUM_LOC_REGS = 9;

  localparam logic [3:0] ADDR_LOC0      = 4'h0;
  localparam logic [3:0] ADDR_LOC8      = 4'h8;
  localparam logic [3:0] ADDR_CTRL      = 4'h9;
  localparam logic [3:0] ADDR_STATUS    = 4'hA;
  localparam logic [3:0] ADDR_SWEEP_IDX = 4'hB;

  localparam int unsigned CTRL_SWEEP_EN_BIT = 0;
  localparam int unsigned CTRL_ACT_EN_BIT   = 1;
  localparam logic [7:0]  CTRL_RST          = 8'h02;

  typedef enum logic {
    SWEEP_IDLE = 1'b0,
    SWEEP_RUN  = 1'b1
  } sweep_state_e;

  // Bit within the SGPIO channel vector that feeds drive n.
  function automatic int unsigned drv_src_bit(input int unsigned n);
    return ((n / GRP_W) / 2) * GRP_W + (n % GRP_W);
  endfunction

  // Odd groups of 12 drives are fed by SGPIO channel 2.
  function automatic bit drv_on_ch2(input int unsigned n);
    return ((n / GRP_W) % 2) == 1;
  endfunction

endpackage

// File: rtl/sgpio_link_wdog.sv
// SGPIO link watchdog: a saturating ms counter cleared by each frame strobe.
// Ports: SYSCLK/RESET (sync, active-high), TICK (1 ms pulse),
//        FRAME (frame-complete pulse), LINK_OK (registered, 1 = link alive).
module sgpio_link_wdog #(
  parameter int unsigned WDOG_MS = 100
) (
  input  logic SYSCLK,
  input  logic RESET,
  input  logic TICK,
  input  logic FRAME,
  output logic LINK_OK
);

  localparam int unsigned    CNT_W   = $clog2(WDOG_MS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_MS);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             link_ok_q;

  // Frame strobe beats a coincident tick; count saturates at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (FRAME) begin
      cnt_d = '0;
    end else if (TICK && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // LINK_OK is registered from the next count so it tracks cnt_q exactly.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      cnt_q     <= CNT_MAX;
      link_ok_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      link_ok_q <= (cnt_d < CNT_MAX);
    end
  end

  assign LINK_OK = link_ok_q;

endmodule

// File: rtl/drv_led_arb.sv
// Per-drive activity LED arbiter. Merges SGPIO activity (gated by per-channel
// link watchdogs), host locate blink and a test sweep into 72 active-low LEDs.
// Ports: SYSCLK/RESET (sync, active-high); ACT_LED1/2 SGPIO activity (active-low);
//        FRAME1/2 frame strobes; REG_WR/REG_RD/REG_ADDR/REG_DIN host register port;
//        REG_DOUT registered read data; DRV_ACT_LED_L registered LED cathodes.
module drv_led_arb
  import status_define::*;
#(
  parameter int unsigned CLK_HZ   = 25_000_000,
  parameter int unsigned WDOG_MS  = 100,
  parameter int unsigned BLINK_MS = 250,
  parameter int unsigned SWEEP_MS = 100
) (
  input  logic               SYSCLK,
  input  logic               RESET,
  input  logic [CH_W-1:0]    ACT_LED1,
  input  logic [CH_W-1:0]    ACT_LED2,
  input  logic               FRAME1,
  input  logic               FRAME2,
  input  logic               REG_WR,
  input  logic               REG_RD,
  input  logic [3:0]         REG_ADDR,
  input  logic [7:0]         REG_DIN,
  output logic [7:0]         REG_DOUT,
  output logic [NUM_DRV-1:0] DRV_ACT_LED_L
);

  localparam int unsigned PRESC_DIV = CLK_HZ / 1000;
  localparam int unsigned PRESC_W   = $clog2(PRESC_DIV + 1);
  localparam int unsigned BLINK_W   = $clog2(BLINK_MS + 1);
  localparam int unsigned SWEEP_W   = $clog2(SWEEP_MS + 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_c;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               blink_q, blink_d;
  sweep_state_e       sweep_q;
  logic [IDX_W-1:0]   sweep_idx_q;
  logic [SWEEP_W-1:0] dwell_q;
  logic [NUM_DRV-1:0] loc_q, loc_d;
  logic [1:0]         ctrl_q, ctrl_d;
  logic [7:0]         dout_q, rdata_c;
  logic [NUM_DRV-1:0] led_q, led_d;
  logic               link1_ok, link2_ok;
  logic [NUM_DRV-1:0] src_c, gate_c;
  logic               wr_ctrl_c;

  // 1 ms tick prescaler.
  assign tick_c  = (presc_q == PRESC_W'(PRESC_DIV - 1));
  assign presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);

  // Locate blink phase, toggling every BLINK_MS ticks.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;
    if (tick_c) begin
      if (blink_cnt_q == BLINK_W'(BLINK_MS - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end
  end

  sgpio_link_wdog #(.WDOG_MS(WDOG_MS)) u_wdog1 (
    .SYSCLK (SYSCLK),
    .RESET  (RESET),
    .TICK   (tick_c),
    .FRAME  (FRAME1),
    .LINK_OK(link1_ok)
  );

  sgpio_link_wdog #(.WDOG_MS(WDOG_MS)) u_wdog2 (
    .SYSCLK (SYSCLK),
    .RESET  (RESET),
    .TICK   (tick_c),
    .FRAME  (FRAME2),
    .LINK_OK(link2_ok)
  );

  // Static drive-to-source wiring: each drive picks its channel bit and link.
  for (genvar n = 0; n < NUM_DRV; n++) begin : g_drv
    localparam int unsigned K = drv_src_bit(n);
    if (drv_on_ch2(n)) begin : g_ch2
      assign src_c[n]  = ACT_LED2[K];
      assign gate_c[n] = link2_ok;
    end else begin : g_ch1
      assign src_c[n]  = ACT_LED1[K];
      assign gate_c[n] = link1_ok;
    end
  end

  // Register file write path.
  assign wr_ctrl_c = REG_WR && (REG_ADDR == ADDR_CTRL);

  always_comb begin
    loc_d  = loc_q;
    ctrl_d = ctrl_q;
    if (REG_WR) begin
      for (int r = 0; r < NUM_LOC_REGS; r++) begin
        if (REG_ADDR == 4'(r)) loc_d[r*8 +: 8] = REG_DIN;
      end
      if (REG_ADDR == ADDR_CTRL) ctrl_d = REG_DIN[1:0];
    end
  end

  // Read mux; sampled on REG_RD from pre-write state.
  always_comb begin
    rdata_c = 8'h00;
    for (int r = 0; r < NUM_LOC_REGS; r++) begin
      if (REG_ADDR == 4'(r)) rdata_c = loc_q[r*8 +: 8];
    end
    case (REG_ADDR)
      ADDR_CTRL:      rdata_c = {6'b0, ctrl_q};
      ADDR_STATUS:    rdata_c = {6'b0, link2_ok, link1_ok};
      ADDR_SWEEP_IDX: rdata_c = {1'b0, sweep_idx_q};
      default:        ;
    endcase
  end

  // Per-drive priority: sweep, then locate, then gated activity, else off.
  always_comb begin
    led_d = '1;
    for (int n = 0; n < NUM_DRV; n++) begin
      if (sweep_q == SWEEP_RUN) begin
        led_d[n] = (sweep_idx_q != IDX_W'(n));
      end else if (loc_q[n]) begin
        led_d[n] = ~blink_q;
      end else if (ctrl_q[CTRL_ACT_EN_BIT] && gate_c[n]) begin
        led_d[n] = src_c[n];
      end
    end
  end

  // Sweep FSM: entering RUN restarts at drive 0; leaving RUN holds the index.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      sweep_q     <= SWEEP_IDLE;
      sweep_idx_q <= '0;
      dwell_q     <= '0;
    end else begin
      case (sweep_q)
        SWEEP_IDLE: begin
          if (wr_ctrl_c && REG_DIN[CTRL_SWEEP_EN_BIT]) begin
            sweep_q     <= SWEEP_RUN;
            sweep_idx_q <= '0;
            dwell_q     <= '0;
          end
        end
        SWEEP_RUN: begin
          if (wr_ctrl_c && !REG_DIN[CTRL_SWEEP_EN_BIT]) begin
            sweep_q <= SWEEP_IDLE;
          end else if (tick_c) begin
            if (dwell_q == SWEEP_W'(SWEEP_MS - 1)) begin
              dwell_q     <= '0;
              sweep_idx_q <= (sweep_idx_q == IDX_W'(NUM_DRV - 1)) ? '0
                                                                  : sweep_idx_q + IDX_W'(1);
            end else begin
              dwell_q <= dwell_q + SWEEP_W'(1);
            end
          end
        end
        default: sweep_q <= SWEEP_IDLE;
      endcase
    end
  end

  // Datapath state registers.
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
      loc_q       <= '0;
      ctrl_q      <= CTRL_RST[1:0];
      dout_q      <= 8'h00;
      led_q       <= '1;
    end else begin
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      loc_q       <= loc_d;
      ctrl_q      <= ctrl_d;
      led_q       <= led_d;
      if (REG_RD) dout_q <= rdata_c;
    end
  end

  assign REG_DOUT      = dout_q;
  assign DRV_ACT_LED_L = led_q;

endmodule

// File: tb/tb_drv_led_arb.sv
// Directed self-checking bench for drv_led_arb with a small expected-value queue.
module tb_drv_led_arb;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic [35:0] ACT_LED1, ACT_LED2;
  logic        FRAME1, FRAME2;
  logic        frame1_man, frame1_auto;
  logic        REG_WR, REG_RD;
  logic [3:0]  REG_ADDR;
  logic [7:0]  REG_DIN;
  logic [7:0]  REG_DOUT;
  logic [71:0] DRV_ACT_LED_L;

  logic        keep1;
  int          keep_cnt;

  typedef struct {
    string       tag;
    logic [71:0] val;
  } exp_t;

  exp_t sbq[$];
  int   n_checks;
  int   n_fail;

  localparam logic [71:0] CH2_MASK = 72'hFFF000_FFF000_FFF000;
  localparam logic [71:0] ONE72    = 72'd1;

  drv_led_arb #(
    .CLK_HZ  (10_000),
    .WDOG_MS (5),
    .BLINK_MS(2),
    .SWEEP_MS(1)
  ) dut (
    .SYSCLK       (SYSCLK),
    .RESET        (RESET),
    .ACT_LED1     (ACT_LED1),
    .ACT_LED2     (ACT_LED2),
    .FRAME1       (FRAME1),
    .FRAME2       (FRAME2),
    .REG_WR       (REG_WR),
    .REG_RD       (REG_RD),
    .REG_ADDR     (REG_ADDR),
    .REG_DIN      (REG_DIN),
    .REG_DOUT     (REG_DOUT),
    .DRV_ACT_LED_L(DRV_ACT_LED_L)
  );

  always #5 SYSCLK = ~SYSCLK;

  assign FRAME1 = frame1_man | frame1_auto;

  // Keeps SGPIO channel 1 alive with a frame every 20 cycles when enabled.
  always @(negedge SYSCLK) begin
    if (keep1) begin
      frame1_auto = (keep_cnt == 0);
      keep_cnt    = (keep_cnt == 19) ? 0 : keep_cnt + 1;
    end else begin
      frame1_auto = 1'b0;
      keep_cnt    = 0;
    end
  end

  task automatic sb_push(input string tag, input logic [71:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input logic [71:0] act);
    exp_t e;
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty: observed %h required an expected entry", act);
    end else begin
      e = sbq.pop_front();
      assert (act === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, act, e.val);
      end
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    REG_WR   = 1'b1;
    REG_ADDR = a;
    REG_DIN  = d;
    @(negedge SYSCLK);
    REG_WR   = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
    sb_push(tag, {64'd0, exp});
    REG_RD   = 1'b1;
    REG_ADDR = a;
    @(negedge SYSCLK);
    REG_RD   = 1'b0;
    sb_check({64'd0, REG_DOUT});
  endtask

  // Cycles until LED bit idx changes (capped at bound).
  task automatic run_len_bit(input int idx, input int bound, output int len);
    logic v;
    v   = DRV_ACT_LED_L[idx];
    len = 0;
    while ((DRV_ACT_LED_L[idx] === v) && (len < bound)) begin
      @(negedge SYSCLK);
      len++;
    end
  endtask

  // Cycles until any LED changes (capped at bound).
  task automatic run_len_vec(input int bound, output int len);
    logic [71:0] v;
    v   = DRV_ACT_LED_L;
    len = 0;
    while ((DRV_ACT_LED_L === v) && (len < bound)) begin
      @(negedge SYSCLK);
      len++;
    end
  endtask

  // Wait until LED bit idx is lit (0); returns 1 on timeout.
  task automatic wait_lit(input int idx, input int bound, output bit to);
    int c;
    c = 0;
    while ((DRV_ACT_LED_L[idx] !== 1'b0) && (c < bound)) begin
      @(negedge SYSCLK);
      c++;
    end
    to = (c >= bound);
  endtask

  initial begin
    int len;
    bit to;
    n_checks    = 0;
    n_fail      = 0;
    keep1       = 1'b0;
    RESET       = 1'b1;
    ACT_LED1    = '1;
    ACT_LED2    = '1;
    frame1_man  = 1'b0;
    FRAME2      = 1'b0;
    REG_WR      = 1'b0;
    REG_RD      = 1'b0;
    REG_ADDR    = 4'h0;
    REG_DIN     = 8'h00;

    // Reset values.
    repeat (3) @(negedge SYSCLK);
    sb_push("rst_led", '1);
    sb_check(DRV_ACT_LED_L);
    sb_push("rst_dout", 72'd0);
    sb_check({64'd0, REG_DOUT});
    RESET = 1'b0;
    rd("rst_ctrl", 4'h9, 8'h02);

    // Channel 1 frame with ACT_LED1[12] lit -> drive 25 (bit 24).
    ACT_LED1 = ~(36'd1 << 12);
    sb_push("act_map", ~(ONE72 << 24));
    frame1_man = 1'b1;
    @(negedge SYSCLK);
    frame1_man = 1'b0;
    @(negedge SYSCLK);
    sb_check(DRV_ACT_LED_L);
    keep1 = 1'b1;
    rd("status_l1", 4'hA, 8'h01);

    // Channel 2: one frame, then silence until the watchdog expires.
    ACT_LED2 = '0;
    FRAME2   = 1'b1;
    @(negedge SYSCLK);
    FRAME2   = 1'b0;
    repeat (37) @(negedge SYSCLK);
    sb_push("l2_alive", ~(CH2_MASK | (ONE72 << 24)));
    sb_check(DRV_ACT_LED_L);
    repeat (20) @(negedge SYSCLK);
    sb_push("l2_dead", ~(ONE72 << 24));
    sb_check(DRV_ACT_LED_L);
    rd("status_l2dead", 4'hA, 8'h01);

    // Locate blink on drive 1 overrides its activity.
    ACT_LED1 = ~((36'd1 << 12) | 36'd1);
    wr(4'h0, 8'h01);
    rd("loc_rd", 4'h0, 8'h01);
    run_len_bit(0, 60, len);
    run_len_bit(0, 60, len);
    sb_push("blink_half1", 72'd20);
    sb_check(72'(len));
    run_len_bit(0, 60, len);
    sb_push("blink_half2", 72'd20);
    sb_check(72'(len));
    wr(4'h0, 8'h00);
    sb_push("loc_off", ~(ONE72 | (ONE72 << 24)));
    @(negedge SYSCLK);
    sb_check(DRV_ACT_LED_L);

    // Test sweep.
    wr(4'h9, 8'h03);
    sb_push("sweep_start", ~ONE72);
    @(negedge SYSCLK);
    sb_check(DRV_ACT_LED_L);
    run_len_vec(15, len);
    sb_push("sweep_idx1", ~(ONE72 << 1));
    sb_check(DRV_ACT_LED_L);
    run_len_vec(15, len);
    sb_push("sweep_dwell", 72'd10);
    sb_check(72'(len));
    sb_push("sweep_idx2", ~(ONE72 << 2));
    sb_check(DRV_ACT_LED_L);
    wait_lit(71, 800, to);
    sb_push("sweep_to71", 72'd0);
    sb_check(72'(to));
    rd("sweep_rd71", 4'hB, 8'd71);
    wait_lit(0, 50, to);
    sb_push("sweep_to0", 72'd0);
    sb_check(72'(to));
    rd("sweep_rd0", 4'hB, 8'd0);
    wr(4'h9, 8'h02);
    sb_push("sweep_off", ~(ONE72 | (ONE72 << 24)));
    @(negedge SYSCLK);
    sb_check(DRV_ACT_LED_L);
    rd("ctrl_rd", 4'h9, 8'h02);

    // Same-cycle read and write returns the old value.
    sb_push("rdwr_old", 72'd0);
    REG_RD   = 1'b1;
    REG_WR   = 1'b1;
    REG_ADDR = 4'h3;
    REG_DIN  = 8'hA5;
    @(negedge SYSCLK);
    REG_RD   = 1'b0;
    REG_WR   = 1'b0;
    sb_check({64'd0, REG_DOUT});
    rd("rdwr_new", 4'h3, 8'hA5);
    wr(4'hA, 8'hFF);
    rd("status_ro", 4'hA, 8'h01);
    wr(4'hC, 8'hFF);
    rd("unused_rd", 4'hC, 8'h00);

    // Reset mid-sweep with locate active.
    wr(4'h9, 8'h03);
    repeat (25) @(negedge SYSCLK);
    rd("pre_rst_ctrl", 4'h9, 8'h03);
    keep1 = 1'b0;
    @(negedge SYSCLK);
    RESET = 1'b1;
    @(negedge SYSCLK);
    sb_push("mid_rst_led", '1);
    sb_check(DRV_ACT_LED_L);
    sb_push("mid_rst_dout", 72'd0);
    sb_check({64'd0, REG_DOUT});
    RESET = 1'b0;
    repeat (3) @(negedge SYSCLK);
    sb_push("post_rst_led", '1);
    sb_check(DRV_ACT_LED_L);
    rd("post_rst_ctrl", 4'h9, 8'h02);
    rd("post_rst_idx", 4'hB, 8'h00);
    rd("post_rst_loc", 4'h3, 8'h00);
    rd("post_rst_status", 4'hA, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
